// File: rtl/apb_vgachargen_bridge.sv
// APB3 slave that maps word transfers onto the byte-wide character/colour maps and the
// 128-bit character table (RMW). Optional read path: APB_VGACHARGEN_BRIDGE_READBACK_EN.
module apb_vgachargen_bridge #(
    parameter int MAP_DEPTH = 2400,
    parameter int CT_DEPTH  = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         psel,
    input  logic         penable,
    input  logic         pwrite,
    input  logic [31:0]  paddr,
    input  logic [31:0]  pwdata,
    input  logic [3:0]   pstrb,
    output logic [31:0]  prdata,
    output logic         pready,
    output logic         pslverr,
    output logic [11:0]  ch_map_addr_o,
    output logic [7:0]   ch_map_data_o,
    output logic         ch_map_wen_o,
    input  logic [7:0]   ch_map_data_i,
    output logic [11:0]  col_map_addr_o,
    output logic [7:0]   col_map_data_o,
    output logic         col_map_wen_o,
    input  logic [7:0]   col_map_data_i,
    output logic [6:0]   ch_t_rw_addr_o,
    output logic [127:0] ch_t_rw_data_o,
    output logic         ch_t_rw_wen_o,
    input  logic [127:0] ch_t_rw_data_i
);

    typedef enum logic [2:0] {IDLE, MAP_WR, MAP_RD, CT_RD, CT_WR, RESP} state_t;

    localparam logic [12:0] MAP_LIMIT = 13'(MAP_DEPTH);
    localparam logic [12:0] CT_LIMIT  = 13'(CT_DEPTH * 16);

    state_t       state_q, state_d;
    logic [9:0]   base_q, base_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   strb_q, strb_d;
    logic         write_q, write_d;
    logic         col_q, col_d;
    logic [2:0]   idx_q, idx_d;
    logic [23:0]  rd_buf_q, rd_buf_d;
    logic [11:0]  map_addr_q, map_addr_d;
    logic [7:0]   map_data_q, map_data_d;
    logic         ch_wen_q, ch_wen_d;
    logic         col_wen_q, col_wen_d;
    logic [6:0]   ct_addr_q, ct_addr_d;
    logic [127:0] ct_data_q, ct_data_d;
    logic         ct_wen_q, ct_wen_d;
    logic [31:0]  prdata_q, prdata_d;
    logic         pready_q, pready_d;
    logic         pslverr_q, pslverr_d;

    logic [3:0]   region;
    logic [12:0]  offset;
    logic         is_map, is_ct, in_range;
    logic [1:0]   lane_in, lane_nx;
    logic [7:0]   map_rd;
    logic [127:0] ct_merged;
    logic         unused_sink;

    function automatic logic [1:0] first_lane(input logic [3:0] m);
        logic [1:0] l;
        casez (m)
            4'b???1: l = 2'd0;
            4'b??10: l = 2'd1;
            4'b?100: l = 2'd2;
            default: l = 2'd3;
        endcase
        return l;
    endfunction

    always_comb begin
        region   = paddr[15:12];
        offset   = {1'b0, paddr[11:0]};
        is_map   = ((region == 4'h0) || (region == 4'h1)) && (offset < MAP_LIMIT);
        is_ct    = (region == 4'h2) && (offset < CT_LIMIT);
        in_range = (paddr[31:16] == 16'h0) && (is_map || is_ct);
        lane_in  = first_lane(pstrb);
        lane_nx  = first_lane(strb_q);
        map_rd   = col_q ? col_map_data_i : ch_map_data_i;
    end

    // Word k of the current table entry, with strobed byte lanes replaced by write data.
    always_comb begin
        ct_merged = ch_t_rw_data_i;
        for (int l = 0; l < 4; l++) begin
            if (strb_q[l]) ct_merged[{base_q[1:0], 5'b0} + 7'(8 * l) +: 8] = wdata_q[8 * l +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        write_d    = write_q;
        col_d      = col_q;
        idx_d      = idx_q;
        rd_buf_d   = rd_buf_q;
        map_addr_d = map_addr_q;
        map_data_d = map_data_q;
        ct_addr_d  = ct_addr_q;
        ct_data_d  = ct_data_q;
        prdata_d   = prdata_q;
        ch_wen_d   = 1'b0;
        col_wen_d  = 1'b0;
        ct_wen_d   = 1'b0;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (psel && penable) begin
                    base_d  = paddr[11:2];
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    write_d = pwrite;
                    col_d   = paddr[12];
                    idx_d   = 3'd0;
                    if (!in_range) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else if (is_ct) begin
                        ct_addr_d = paddr[10:4];
                        if (pwrite) begin
                            state_d = CT_RD;
                        end else begin
`ifdef APB_VGACHARGEN_BRIDGE_READBACK_EN
                            state_d = CT_RD;
`else
                            state_d  = RESP;
                            pready_d = 1'b1;
                            prdata_d = '0;
`endif
                        end
                    end else if (pwrite) begin
                        if (pstrb == 4'b0000) begin
                            state_d  = RESP;
                            pready_d = 1'b1;
                        end else begin
                            map_addr_d = {paddr[11:2], lane_in};
                            map_data_d = pwdata[{lane_in, 3'b000} +: 8];
                            ch_wen_d   = !paddr[12];
                            col_wen_d  = paddr[12];
                            strb_d     = pstrb & ~(4'b0001 << lane_in);
                            state_d    = MAP_WR;
                        end
                    end else begin
`ifdef APB_VGACHARGEN_BRIDGE_READBACK_EN
                        map_addr_d = {paddr[11:2], 2'd0};
                        state_d    = MAP_RD;
`else
                        state_d  = RESP;
                        pready_d = 1'b1;
                        prdata_d = '0;
`endif
                    end
                end
            end
            MAP_WR: begin
                if (strb_q != 4'b0000) begin
                    map_addr_d = {base_q, lane_nx};
                    map_data_d = wdata_q[{lane_nx, 3'b000} +: 8];
                    ch_wen_d   = !col_q;
                    col_wen_d  = col_q;
                    strb_d     = strb_q & ~(4'b0001 << lane_nx);
                end else begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                end
            end
            MAP_RD: begin
`ifdef APB_VGACHARGEN_BRIDGE_READBACK_EN
                // idx counts cycles since lane 0 was presented; data trails the address by one.
                idx_d = idx_q + 3'd1;
                case (idx_q)
                    3'd0: map_addr_d = {base_q, 2'd1};
                    3'd1: begin
                        rd_buf_d[7:0] = map_rd;
                        map_addr_d    = {base_q, 2'd2};
                    end
                    3'd2: begin
                        rd_buf_d[15:8] = map_rd;
                        map_addr_d     = {base_q, 2'd3};
                    end
                    3'd3: rd_buf_d[23:16] = map_rd;
                    default: begin
                        prdata_d = {map_rd, rd_buf_q};
                        pready_d = 1'b1;
                        state_d  = RESP;
                    end
                endcase
`else
                state_d = IDLE;
`endif
            end
            CT_RD: begin
                if (write_q) begin
                    state_d = CT_WR;
                end else begin
`ifdef APB_VGACHARGEN_BRIDGE_READBACK_EN
                    if (idx_q == 3'd0) begin
                        idx_d = 3'd1;
                    end else begin
                        prdata_d = ch_t_rw_data_i[{base_q[1:0], 5'b0} +: 32];
                        pready_d = 1'b1;
                        state_d  = RESP;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            CT_WR: begin
                ct_wen_d  = 1'b1;
                ct_data_d = ct_merged;
                pready_d  = 1'b1;
                state_d   = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            map_addr_q <= '0;
            map_data_q <= '0;
            ch_wen_q   <= 1'b0;
            col_wen_q  <= 1'b0;
            ct_addr_q  <= '0;
            ct_data_q  <= '0;
            ct_wen_q   <= 1'b0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            map_addr_q <= map_addr_d;
            map_data_q <= map_data_d;
            ch_wen_q   <= ch_wen_d;
            col_wen_q  <= col_wen_d;
            ct_addr_q  <= ct_addr_d;
            ct_data_q  <= ct_data_d;
            ct_wen_q   <= ct_wen_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
        end
    end

    // Request latches are fully reloaded on acceptance, so they carry no reset.
    always_ff @(posedge clk) begin
        base_q   <= base_d;
        wdata_q  <= wdata_d;
        strb_q   <= strb_d;
        write_q  <= write_d;
        col_q    <= col_d;
        idx_q    <= idx_d;
        rd_buf_q <= rd_buf_d;
    end

`ifdef APB_VGACHARGEN_BRIDGE_READBACK_EN
    assign unused_sink = ^paddr[1:0];
`else
    assign unused_sink = ^{paddr[1:0], map_rd, idx_q, rd_buf_q};
`endif

    assign prdata         = prdata_q;
    assign pready         = pready_q;
    assign pslverr        = pslverr_q;
    assign ch_map_addr_o  = map_addr_q;
    assign ch_map_data_o  = map_data_q;
    assign ch_map_wen_o   = ch_wen_q;
    assign col_map_addr_o = map_addr_q;
    assign col_map_data_o = map_data_q;
    assign col_map_wen_o  = col_wen_q;
    assign ch_t_rw_addr_o = ct_addr_q;
    assign ch_t_rw_data_o = ct_data_q;
    assign ch_t_rw_wen_o  = ct_wen_q;

endmodule

// File: tb/tb_apb_vgachargen_bridge.sv
// Directed bench for apb_vgachargen_bridge with behavioural 1-cycle-latency memories.
`timescale 1ns/1ps
module tb_apb_vgachargen_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, psel, penable, pwrite;
    logic [31:0]  paddr, pwdata, prdata;
    logic [3:0]   pstrb;
    logic         pready, pslverr;
    logic [11:0]  ch_map_addr_o, col_map_addr_o;
    logic [7:0]   ch_map_data_o, col_map_data_o, ch_map_data_i, col_map_data_i;
    logic         ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o;
    logic [6:0]   ch_t_rw_addr_o;
    logic [127:0] ch_t_rw_data_o, ch_t_rw_data_i;

    apb_vgachargen_bridge dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .ch_map_addr_o(ch_map_addr_o), .ch_map_data_o(ch_map_data_o),
        .ch_map_wen_o(ch_map_wen_o), .ch_map_data_i(ch_map_data_i),
        .col_map_addr_o(col_map_addr_o), .col_map_data_o(col_map_data_o),
        .col_map_wen_o(col_map_wen_o), .col_map_data_i(col_map_data_i),
        .ch_t_rw_addr_o(ch_t_rw_addr_o), .ch_t_rw_data_o(ch_t_rw_data_o),
        .ch_t_rw_wen_o(ch_t_rw_wen_o), .ch_t_rw_data_i(ch_t_rw_data_i)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int multi_wen = 0;

    logic [7:0]   ch_mem  [4096];
    logic [7:0]   col_mem [4096];
    logic [127:0] ct_mem  [128];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ch_map_data_i  <= ch_mem[ch_map_addr_o];
        col_map_data_i <= col_mem[col_map_addr_o];
        ch_t_rw_data_i <= ct_mem[ch_t_rw_addr_o];
        if (ch_map_wen_o)  ch_mem[ch_map_addr_o]   <= ch_map_data_o;
        if (col_map_wen_o) col_mem[col_map_addr_o] <= col_map_data_o;
        if (ch_t_rw_wen_o) ct_mem[ch_t_rw_addr_o]  <= ch_t_rw_data_o;
    end

    // Write log: sel 0 = char map, 1 = colour map, 2 = char table
    int           wq_sel [$];
    int           wq_addr[$];
    int           wq_cyc [$];
    logic [127:0] wq_data[$];

    always @(negedge clk) begin
        if (ch_map_wen_o) begin
            wq_sel.push_back(0); wq_addr.push_back(int'(ch_map_addr_o));
            wq_cyc.push_back(cyc); wq_data.push_back({120'd0, ch_map_data_o});
        end
        if (col_map_wen_o) begin
            wq_sel.push_back(1); wq_addr.push_back(int'(col_map_addr_o));
            wq_cyc.push_back(cyc); wq_data.push_back({120'd0, col_map_data_o});
        end
        if (ch_t_rw_wen_o) begin
            wq_sel.push_back(2); wq_addr.push_back(int'(ch_t_rw_addr_o));
            wq_cyc.push_back(cyc); wq_data.push_back(ch_t_rw_data_o);
        end
        if (int'(ch_map_wen_o) + int'(col_map_wen_o) + int'(ch_t_rw_wen_o) > 1) multi_wen++;
    end

    task automatic clear_log();
        wq_sel.delete(); wq_addr.delete(); wq_cyc.delete(); wq_data.delete();
    endtask

    task automatic apb(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       input logic wr, output logic [31:0] rd, output logic err,
                       output int a, output int lat);
        clear_log();
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = addr; pwdata = data; pstrb = strb; pwrite = wr;
        @(negedge clk);
        penable = 1'b1;
        a = cyc;
        lat = -1; rd = '0; err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pready) begin
                lat = cyc - a; rd = prdata; err = pslverr;
                break;
            end
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(negedge clk);
        total++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0 || ch_map_wen_o !== 1'b0 ||
            col_map_wen_o !== 1'b0 || ch_t_rw_wen_o !== 1'b0 || ch_map_addr_o !== 12'h0 ||
            col_map_addr_o !== 12'h0 || ch_t_rw_addr_o !== 7'h0 || ch_map_data_o !== 8'h0 ||
            col_map_data_o !== 8'h0 || ch_t_rw_data_o !== 128'h0) begin
            bad++;
            $display("FAIL reset_values: pready=%b pslverr=%b prdata=%h wen=%b%b%b addr=%h/%h/%h, required all 0",
                     pready, pslverr, prdata, ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o,
                     ch_map_addr_o, col_map_addr_o, ch_t_rw_addr_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0 ||
                ch_map_wen_o !== 1'b0 || col_map_wen_o !== 1'b0 || ch_t_rw_wen_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_cycle%0d: pready=%b pslverr=%b prdata=%h wen=%b%b%b, required all 0",
                         i, pready, pslverr, prdata, ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o);
            end
        end
    endtask

    task automatic test_map_write();
        logic [31:0] rd; logic err; int a, lat;
        apb(32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b1, rd, err, a, lat);
        total++;
        if (lat !== 5 || wq_sel.size() !== 4) begin
            bad++;
            $display("FAIL map_wr_full: latency=%0d writes=%0d, required latency=5 writes=4", lat, wq_sel.size());
        end
        apb(32'h0000_0010, 32'h4433_2211, 4'b1010, 1'b1, rd, err, a, lat);
        total++;
        if (lat !== 3 || err !== 1'b0) begin
            bad++;
            $display("FAIL map_wr_latency: latency=%0d err=%b, required 3/0", lat, err);
        end
        total++;
        if (wq_sel.size() !== 2) begin
            bad++;
            $display("FAIL map_wr_count: writes=%0d, required 2", wq_sel.size());
        end else begin
            total++;
            if (wq_sel[0] !== 0 || wq_addr[0] !== 17 || wq_data[0][7:0] !== 8'h22 || wq_cyc[0] !== a + 1) begin
                bad++;
                $display("FAIL map_wr_lane1: sel=%0d addr=%0d data=%h cyc=A+%0d, required 0/17/22/A+1",
                         wq_sel[0], wq_addr[0], wq_data[0][7:0], wq_cyc[0] - a);
            end
            total++;
            if (wq_sel[1] !== 0 || wq_addr[1] !== 19 || wq_data[1][7:0] !== 8'h44 || wq_cyc[1] !== a + 2) begin
                bad++;
                $display("FAIL map_wr_lane3: sel=%0d addr=%0d data=%h cyc=A+%0d, required 0/19/44/A+2",
                         wq_sel[1], wq_addr[1], wq_data[1][7:0], wq_cyc[1] - a);
            end
        end
    endtask

    task automatic test_zero_strb();
        logic [31:0] rd; logic err; int a, lat;
        apb(32'h0000_0020, 32'hDEAD_BEEF, 4'b0000, 1'b1, rd, err, a, lat);
        total++;
        if (lat !== 1 || err !== 1'b0 || wq_sel.size() !== 0) begin
            bad++;
            $display("FAIL map_wr_nostrb: latency=%0d err=%b writes=%0d, required 1/0/0", lat, err, wq_sel.size());
        end
    endtask

    task automatic test_map_read();
        logic [31:0] rd, exp_col, exp_ch; logic err; int a, lat, exp_lat;
        apb(32'h0000_1008, 32'h0D0C_0B0A, 4'b1111, 1'b1, rd, err, a, lat);
        total++;
        if (lat !== 5 || wq_sel.size() !== 4 || wq_sel[0] !== 1 || wq_addr[3] !== 11) begin
            bad++;
            $display("FAIL col_preload: latency=%0d writes=%0d, required 5/4 colour writes", lat, wq_sel.size());
        end
`ifdef APB_VGACHARGEN_BRIDGE_READBACK_EN
        exp_col = 32'h0D0C_0B0A; exp_ch = 32'h4400_2200; exp_lat = 6;
`else
        exp_col = 32'h0; exp_ch = 32'h0; exp_lat = 1;
`endif
        apb(32'h0000_1008, 32'h0, 4'b0000, 1'b0, rd, err, a, lat);
        total++;
        if (rd !== exp_col || lat !== exp_lat || err !== 1'b0 || wq_sel.size() !== 0) begin
            bad++;
            $display("FAIL col_read: prdata=%h latency=%0d err=%b writes=%0d, required %h/%0d/0/0",
                     rd, lat, err, wq_sel.size(), exp_col, exp_lat);
        end
        apb(32'h0000_0010, 32'h0, 4'b0101, 1'b0, rd, err, a, lat);
        total++;
        if (rd !== exp_ch || lat !== exp_lat || err !== 1'b0) begin
            bad++;
            $display("FAIL ch_read: prdata=%h latency=%0d err=%b, required %h/%0d/0", rd, lat, err, exp_ch, exp_lat);
        end
        apb(32'h0000_0030, 32'h0000_0077, 4'b0001, 1'b1, rd, err, a, lat);
        total++;
        if (prdata !== exp_ch || lat !== 2) begin
            bad++;
            $display("FAIL prdata_hold: prdata=%h latency=%0d, required %h/2", prdata, lat, exp_ch);
        end
    endtask

    task automatic test_ct();
        logic [31:0] rd, exp_rd; logic err; int a, lat, exp_lat;
        logic [127:0] exp_word;
        for (int w = 0; w < 4; w++) begin
            apb(32'h0000_2050 + 32'(4 * w), 32'hFFFF_FFFF, 4'b1111, 1'b1, rd, err, a, lat);
            total++;
            if (lat !== 3 || wq_sel.size() !== 1 || wq_sel[0] !== 2 || wq_addr[0] !== 5) begin
                bad++;
                $display("FAIL ct_preload%0d: latency=%0d writes=%0d, required 3/1 at entry 5", w, lat, wq_sel.size());
            end
        end
        total++;
        if (wq_data.size() !== 1 || wq_data[0] !== {128{1'b1}}) begin
            bad++;
            $display("FAIL ct_preload_data: writes=%0d, required one all-ones write", wq_data.size());
        end
        exp_word = {128{1'b1}};
        exp_word[71:64] = 8'h00;
        apb(32'h0000_2058, 32'h0000_0000, 4'b0001, 1'b1, rd, err, a, lat);
        total++;
        if (lat !== 3 || err !== 1'b0) begin
            bad++;
            $display("FAIL ct_wr_latency: latency=%0d err=%b, required 3/0", lat, err);
        end
        total++;
        if (wq_sel.size() !== 1) begin
            bad++;
            $display("FAIL ct_wr_count: writes=%0d, required 1", wq_sel.size());
        end else begin
            total++;
            if (wq_sel[0] !== 2 || wq_addr[0] !== 5 || wq_data[0] !== exp_word || wq_cyc[0] !== a + 3) begin
                bad++;
                $display("FAIL ct_wr_merge: addr=%0d data=%h cyc=A+%0d, required 5/%h/A+3",
                         wq_addr[0], wq_data[0], wq_cyc[0] - a, exp_word);
            end
        end
`ifdef APB_VGACHARGEN_BRIDGE_READBACK_EN
        exp_rd = 32'hFFFF_FF00; exp_lat = 3;
`else
        exp_rd = 32'h0; exp_lat = 1;
`endif
        apb(32'h0000_2058, 32'h0, 4'b0000, 1'b0, rd, err, a, lat);
        total++;
        if (rd !== exp_rd || lat !== exp_lat || err !== 1'b0 || wq_sel.size() !== 0) begin
            bad++;
            $display("FAIL ct_read: prdata=%h latency=%0d err=%b writes=%0d, required %h/%0d/0/0",
                     rd, lat, err, wq_sel.size(), exp_rd, exp_lat);
        end
    endtask

    task automatic test_slverr();
        logic [31:0] rd; logic err; int a, lat;
        logic [31:0] bad_addr [5];
        logic        bad_wr   [5];
        bad_addr = '{32'h0000_0960, 32'h0000_3000, 32'h0000_2800, 32'h0001_0000, 32'h0000_1960};
        bad_wr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            apb(bad_addr[i], 32'hA5A5_A5A5, 4'b1111, bad_wr[i], rd, err, a, lat);
            total++;
            if (err !== 1'b1 || lat !== 1 || wq_sel.size() !== 0) begin
                bad++;
                $display("FAIL slverr_%h: err=%b latency=%0d writes=%0d, required 1/1/0",
                         bad_addr[i], err, lat, wq_sel.size());
            end
        end
        apb(32'h0000_095C, 32'hC300_0000, 4'b1000, 1'b1, rd, err, a, lat);
        total++;
        if (err !== 1'b0 || lat !== 2 || wq_sel.size() !== 1 || wq_addr[0] !== 12'h95F || wq_data[0][7:0] !== 8'hC3) begin
            bad++;
            $display("FAIL last_entry_wr: err=%b latency=%0d writes=%0d, required 0/2/1 at 0x95F", err, lat, wq_sel.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int a, lat, seen_pready, wen_after;
        clear_log();
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0040; pwdata = 32'h1122_3344;
        pstrb = 4'b1111; pwrite = 1'b1;
        @(negedge clk);
        penable = 1'b1;
        a = cyc;
        @(negedge clk);
        rst = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wen_after = int'(ch_map_wen_o) + int'(col_map_wen_o) + int'(ch_t_rw_wen_o);
        seen_pready = int'(pready);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pready) seen_pready++;
            wen_after += int'(ch_map_wen_o) + int'(col_map_wen_o) + int'(ch_t_rw_wen_o);
        end
        total++;
        if (seen_pready !== 0 || wen_after !== 0) begin
            bad++;
            $display("FAIL rst_mid_abort: pready_cycles=%0d wen_cycles=%0d, required 0/0", seen_pready, wen_after);
        end
        total++;
        if (wq_sel.size() !== 1 || wq_addr[0] !== 64 || wq_cyc[0] !== a + 1) begin
            bad++;
            $display("FAIL rst_mid_partial: writes=%0d, required 1 (entry 64 at A+1)", wq_sel.size());
        end
        apb(32'h0000_0044, 32'h0000_AB00, 4'b0010, 1'b1, rd, err, a, lat);
        total++;
        if (lat !== 2 || err !== 1'b0 || wq_sel.size() !== 1 || wq_addr[0] !== 69 || wq_data[0][7:0] !== 8'hAB) begin
            bad++;
            $display("FAIL rst_mid_recover: latency=%0d err=%b writes=%0d, required 2/0/1 at entry 69 data ab",
                     lat, err, wq_sel.size());
        end
    endtask

    initial begin
        test_reset();
        test_map_write();
        test_zero_strb();
        test_map_read();
        test_ct();
        test_slverr();
        test_reset_mid();
        total++;
        if (multi_wen !== 0) begin
            bad++;
            $display("FAIL single_wen: cycles_with_multiple_wen=%0d, required 0", multi_wen);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_vgachargen_bridge.md
# apb_vgachargen_bridge

APB3 slave that sits directly upstream of the VGA text-mode top and drives its three port-A memory interfaces: character map, colour map and writable character table. It turns 32-bit APB transfers with byte strobes into sequences of byte-wide map accesses or 128-bit read-modify-write accesses to the character table. All accesses run on the system clock `clk`, the same clock as port A of the text-mode memories.

## Interface
- `MAP_DEPTH`, 2400: entries in the character map and in the colour map (80×30).
- `CT_DEPTH`, 128: entries in the writable character table.
- `clk` in 1: system clock, which is also port-A clock of all memories.
- `rst` in 1: reset, synchronous and active-high.
- `psel`, `penable`, `pwrite` in 1: APB3 control.
- `paddr` in 32: byte address; bits [1:0] are ignored.
- `pwdata` in 32, `pstrb` in 4: write data and byte strobes.
- `prdata` out 32, `pready` out 1, `pslverr` out 1: APB response.
- `ch_map_addr_o` out 12, `ch_map_data_o` out 8, `ch_map_wen_o` out 1, `ch_map_data_i` in 8: character map port A.
- `col_map_addr_o` out 12, `col_map_data_o` out 8, `col_map_wen_o` out 1, `col_map_data_i` in 8: colour map port A.
- `ch_t_rw_addr_o` out 7, `ch_t_rw_data_o` out 128, `ch_t_rw_wen_o` out 1, `ch_t_rw_data_i` in 128: character table port A.
- Memory read latency is 1 cycle: `*_data_i` is valid in the cycle after its address is presented.

## Operation
- Address map, by `paddr[15:12]`:
  - 0x0: character map. Byte offset = entry index. Valid range 0x000–0x95F.
  - 0x1: colour map. Same layout as the character map.
  - 0x2: character table. Offset[10:4] = entry; offset[3:2] = word k, which maps to bits [32k+31:32k]. Valid range 0x000–0x7FF.
  - Any other address, any offset at or beyond the region size, or `paddr[31:16]` ≠ 0 is out of range.
- States: IDLE, MAP_WR, MAP_RD, CT_RD, CT_WR, RESP.
- IDLE: a cycle with `psel&penable` starts a transfer. Let A be that cycle. The block latches address, data and strobes, then moves to the state for the decoded operation.
  - An out-of-range transfer goes straight to RESP with `pslverr`=1.
- MAP_WR: one byte per cycle, lanes in ascending order, lanes with a clear strobe skipped.
  - Entry = word base + lane. Data = `pwdata[8l+7:8l]`. `wen`=1 only on the selected map.
  - Goes to RESP after the last set lane. `pstrb`=0 goes to RESP directly with no write.
- MAP_RD:
  - Issues addresses for lanes 0..3 in consecutive cycles.
  - Captures each `*_data_i` one cycle after its address into the `prdata` byte for that lane.
  - Goes to RESP after the lane-3 capture.
  - `pstrb` is ignored.
- CT_RD:
  - Issues the entry address.
  - Read: the next cycle captures word k of `ch_t_rw_data_i` into `prdata`, then goes to RESP.
  - Write: goes to CT_WR.
- CT_WR: asserts `ch_t_rw_wen_o` for one cycle with `ch_t_rw_data_i`, with word k lanes replaced by `pwdata` where `pstrb` is set. Then goes to RESP.
- RESP: `pready`=1 for exactly one cycle, then IDLE.
  - `prdata` holds until the next read completes.
  - `pslverr` is valid only with `pready`.
- `psel`/`penable` changes after A are ignored; the operation always completes.
- No new transfer is accepted outside IDLE.

## Timing
- Reset values: `pready`=0, `pslverr`=0, `prdata`=0, all `wen`=0, all addresses and write data 0, state IDLE.
- Reset mid-operation:
  - All `wen` are low in the cycle after `rst` is sampled.
  - An in-progress write may be partially applied.
  - No `pready` is issued for the aborted transfer.
- Cycle of the `pready`=1 cycle:
  - Map write: A+1+N, where N = popcount(`pstrb`).
  - Map read: A+6.
  - Character table read or write: A+3.
  - Out-of-range: A+1.
- At most one `wen` is high per cycle. Address outputs are registered.

## Configuration
- `APB_VGACHARGEN_BRIDGE_READBACK_EN`
  - Defined: MAP_RD and character table read behave as above.
  - Undefined: every in-range read goes straight to RESP (`pready` at A+1) with `prdata`=0 and `pslverr`=0. `*_data_i` are unused, except `ch_t_rw_data_i` for the character table write merge, which is still performed.

## Test plan
- Reset, then idle for 5 cycles → `pready`, `pslverr`, `prdata` and all `wen` stay 0.
- Write 0x44332211 to 0x0010 with `pstrb`=0b1010 → `ch_map_wen_o` pulses at A+1 (addr 17, data 0x22) and A+2 (addr 19, data 0x44). `pready` at A+3.
- Preload colour map entries 8..11 = 0x0A,0x0B,0x0C,0x0D, then read 0x1008 → `prdata`=0x0D0C0B0A and `pready` at A+6. Without the macro: `prdata`=0 and `pready` at A+1.
- Character table entry 5 = all-ones; write 0x00000000 to 0x2058 with `pstrb`=0b0001 → one write to addr 5 with bits [71:64] cleared and all other bits set. `pready` at A+3.
- Access 0x0960, 0x3000 and 0x2800 → `pslverr`=1 with `pready` at A+1 and no `wen`.
- Assert `rst` during MAP_WR after the first lane → no further `wen`, no `pready`. A following transfer completes normally.
